// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: machine word and direct-mapped icache views.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Default geometry (16 frames, one word per frame)
    localparam int ICACHE_IDX_W = 4;
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        ICACHE_IDLE,
        ICACHE_FETCH
    } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache with single-outstanding
// refill. Optional performance counters are built when ICACHE_PERF_EN is
// defined; otherwise hit_count/miss_count are tied to zero.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t      state_q, state_d;
    logic [29:0]        miss_word_q, miss_word_d;
    logic               discard_q, discard_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [SETS];
    logic [TAG_W-1:0]   tag_d [SETS];
    word_t              data_q [SETS];
    word_t              data_d [SETS];

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic               lookup_hit;
    logic               fill_en;
    logic               unused_byteoff;

    assign req_idx        = imemaddr[IDX_W+1:2];
    assign req_tag        = imemaddr[31:IDX_W+2];
    assign miss_idx       = miss_word_q[IDX_W-1:0];
    assign miss_tag       = miss_word_q[29:IDX_W];
    assign lookup_hit     = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_byteoff = ^imemaddr[1:0];

    // State register with synchronous reset; valid bits live here too
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q     <= ICACHE_IDLE;
            miss_word_q <= '0;
            discard_q   <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_word_q <= miss_word_d;
            discard_q   <= discard_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data storage carry no reset; only valid bits matter
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // Next-state: miss latches the word address, fill completes on iwait low
    always_comb begin
        state_d     = state_q;
        miss_word_d = miss_word_q;
        discard_d   = discard_q;
        unique case (state_q)
            ICACHE_IDLE: begin
                discard_d = 1'b0;
                if (imemREN && !lookup_hit && !flush) begin
                    state_d     = ICACHE_FETCH;
                    miss_word_d = imemaddr[31:2];
                end
            end
            ICACHE_FETCH: begin
                if (!iwait) begin
                    state_d   = ICACHE_IDLE;
                    discard_d = 1'b0;
                end else if (flush) begin
                    // Remember the flush so a later fill word is dropped
                    discard_d = 1'b1;
                end
            end
            default: state_d = ICACHE_IDLE;
        endcase
    end

    // Outputs: combinational hit path and memory request
    always_comb begin
        ihit     = (state_q == ICACHE_IDLE) && lookup_hit && !flush;
        imemload = ihit ? data_q[req_idx] : '0;
        iREN     = (state_q == ICACHE_FETCH);
        iaddr    = {miss_word_q, 2'b00};
        fill_en  = (state_q == ICACHE_FETCH) && !iwait && !flush && !discard_q;
    end

    // Frame update: fill overwrites the indexed frame, flush clears all valids
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[miss_idx] = 1'b1;
            tag_d[miss_idx]   = miss_tag;
            data_d[miss_idx]  = iload;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Counters advance on served hits and on each refill launch
    always_comb begin
        hit_count_d  = hit_count_q + {31'b0, ihit};
        miss_count_d = miss_count_q +
                       {31'b0, (state_q == ICACHE_IDLE) && (state_d == ICACHE_FETCH)};
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge CLK) begin
        if (nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: driver pushes expected responses,
// monitor pops on ihit, memory responder checks refill addresses.
module tb_icache_direct;

    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 CLK = ~CLK;

    icache_direct #(.SETS(SETS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    int unsigned checks = 0;
    int unsigned fails  = 0;
    int          cyc    = 0;
    int          req_start = 0;
    int          mem_wait  = 0;
    exp_t        exp_q[$];
    logic [31:0] fill_q[$];
    logic [31:0] mem_over[logic [31:0]];

    // Reference cache contents
    bit          ref_valid [SETS];
    logic [25:0] ref_tag   [SETS];
    logic [31:0] ref_data  [SETS];
    int unsigned hits_exp, misses_exp;

    // Responder state
    bit          in_f = 1'b0;
    int          fcnt = 0;
    logic [31:0] cur_fill = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return a * 32'h9E3779B1 + 32'h00001357;
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[a[5:2]] && (ref_tag[a[5:2]] == a[31:6]);
    endfunction

    task automatic ref_fill(input logic [31:0] a);
        ref_valid[a[5:2]] = 1'b1;
        ref_tag[a[5:2]]   = a[31:6];
        ref_data[a[5:2]]  = mem_word(a);
    endtask

    task automatic ref_flush();
        for (int i = 0; i < SETS; i++) ref_valid[i] = 1'b0;
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: every served fetch must match the front of the scoreboard
    initial forever begin
        exp_t e;
        @(negedge CLK);
        if (nRST !== 1'b0) continue;
        if (ihit === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ihit: got ihit=1 expected no pending fetch (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("imemload", imemload, e.data);
                check("hit_latency", 32'(cyc - req_start), 32'(e.lat));
            end
        end else begin
            check("imemload_zero_on_no_hit", imemload, 32'h0);
        end
    end

    // Memory model: holds iwait for mem_wait cycles, checks refill address
    initial begin
        iwait = 1'b1;
        iload = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (nRST) begin
                in_f  = 1'b0;
                iwait = 1'b1;
            end else if (iREN) begin
                if (!in_f) begin
                    in_f = 1'b1;
                    fcnt = 0;
                    if (fill_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_refill: got iaddr=%h expected no refill", iaddr);
                        cur_fill = iaddr;
                    end else begin
                        cur_fill = fill_q.pop_front();
                    end
                end else begin
                    fcnt++;
                end
                check("iaddr", iaddr, cur_fill);
                iwait = (fcnt < mem_wait);
                iload = iwait ? 32'hDEADBEEF : mem_word(iaddr);
            end else begin
                if (in_f) begin
                    check("refill_len", 32'(fcnt), 32'(mem_wait));
                    in_f = 1'b0;
                end
                iwait = 1'($urandom_range(0, 1));
                iload = $urandom;
            end
        end
    end

    // Generic request: holds imemREN until ihit, optional flush / address change
    task automatic req_raw(input logic [31:0] a, input int w, input int flush_at,
                           input int chg_at, input logic [31:0] chg_a,
                           input int exp_lat, input logic [31:0] exp_data);
        exp_t e;
        int   k;
        bit   got;
        e.data = exp_data;
        e.lat  = exp_lat;
        exp_q.push_back(e);
        k   = 0;
        got = 1'b0;
        @(posedge CLK);
        #1;
        mem_wait  = w;
        imemaddr  = a;
        imemREN   = 1'b1;
        req_start = cyc;
        while (!got && k < 80) begin
            if (k > 0) begin
                @(posedge CLK);
                #1;
            end
            flush = (k == flush_at);
            if (k == chg_at) imemaddr = chg_a;
            @(negedge CLK);
            if (ihit === 1'b1) got = 1'b1;
            k++;
        end
        flush = 1'b0;
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL fetch_timeout: got no ihit expected ihit for addr %h", a);
            exp_q.delete();
            fill_q.delete();
        end
    endtask

    // Plain request predicted by the reference cache
    task automatic do_req(input logic [31:0] a, input int w);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        hits_exp++;
        if (ref_hit(wa)) begin
            req_raw(a, w, -1, -1, 32'h0, 0, ref_data[wa[5:2]]);
        end else begin
            fill_q.push_back(wa);
            misses_exp++;
            ref_fill(wa);
            req_raw(a, w, -1, -1, 32'h0, w + 2, ref_data[wa[5:2]]);
        end
    endtask

    task automatic flush_cycle();
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
        flush   = 1'b1;
        ref_flush();
    endtask

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
        imemREN  = 1'b0;
        flush    = 1'b0;
        imemaddr = $urandom;
        @(negedge CLK);
        check("ihit_without_request", {31'b0, ihit}, 32'h0);
    endtask

    task automatic chk_counters();
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
        flush   = 1'b0;
        @(negedge CLK);
`ifdef ICACHE_PERF_EN
        check("hit_count", hit_count, hits_exp);
        check("miss_count", miss_count, misses_exp);
`else
        check("hit_count", hit_count, 32'h0);
        check("miss_count", miss_count, 32'h0);
`endif
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        nRST     = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        flush    = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("reset_ihit", {31'b0, ihit}, 32'h0);
        check("reset_iREN", {31'b0, iREN}, 32'h0);
        check("reset_iaddr", iaddr, 32'h0);
        check("reset_imemload", imemload, 32'h0);
        check("reset_hit_count", hit_count, 32'h0);
        check("reset_miss_count", miss_count, 32'h0);
        @(posedge CLK);
        #1;
        nRST    = 1'b0;
        imemREN = 1'b0;
        ref_flush();
        hits_exp   = 0;
        misses_exp = 0;
        exp_q.delete();
        fill_q.delete();
    endtask

    logic [25:0] tags [4];

    initial begin
        logic [31:0] a;
        int          r;
        int          w;
        nRST     = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        flush    = 1'b0;
        tags[0] = 26'h0;
        tags[1] = 26'h1;
        tags[2] = 26'h2AAAAAA;
        tags[3] = 26'h3FFFFFF;
        mem_over[32'h0000_0004] = 32'h8C010000;
        mem_over[32'h0000_0000] = 32'hAAAA0000;
        mem_over[32'h0000_0040] = 32'hBBBB0000;

        do_reset();

        // Cold miss, then hits on the same word (10 hit cycles in all)
        do_req(32'h4, 2);
        for (int i = 0; i < 9; i++) do_req(32'h4, 3);
        chk_counters();

        // Conflict eviction on index 0
        do_reset();
        do_req(32'h00, 1);
        do_req(32'h40, 1);
        do_req(32'h00, 1);
        chk_counters();

        // Flush invalidates a warm frame
        do_req(32'h08, 1);
        do_req(32'h08, 0);
        flush_cycle();
        do_req(32'h08, 1);

        // Flush in the fill cycle: word dropped, request refetches
        flush_cycle();
        w = 2;
        fill_q.push_back(32'h08);
        fill_q.push_back(32'h08);
        misses_exp += 2;
        hits_exp++;
        ref_fill(32'h08);
        req_raw(32'h08, w, w + 1, -1, 32'h0, 2 * (w + 2), mem_word(32'h08));

        // Flush alongside a would-be hit suppresses it and forces a refill
        w = 1;
        fill_q.push_back(32'h08);
        misses_exp++;
        hits_exp++;
        ref_flush();
        ref_fill(32'h08);
        req_raw(32'h08, w, 0, -1, 32'h0, w + 3, mem_word(32'h08));

        // Address changes during FETCH: fill goes to latched 0x10, then 0x14 misses
        flush_cycle();
        w = 3;
        fill_q.push_back(32'h10);
        fill_q.push_back(32'h14);
        misses_exp += 2;
        hits_exp++;
        ref_fill(32'h10);
        ref_fill(32'h14);
        req_raw(32'h10, w, -1, 2, 32'h14, 2 * (w + 2), mem_word(32'h14));
        do_req(32'h10, 2);
        do_req(32'h14, 2);
        chk_counters();

        // Randomized traffic over a small set of conflicting addresses
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                flush_cycle();
            end else if (r == 1) begin
                idle_cycle();
            end else begin
                a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                do_req(a, $urandom_range(0, 3));
            end
        end
        chk_counters();

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        check("refills_drained", 32'(fill_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, one-word-per-block instruction cache between the pipelined datapath's fetch port and the memory controller. It answers fetch requests combinationally on a hit. On a miss it runs a single-outstanding refill from memory, writes the returned word into the frame, and then serves the fetch from the cache.

## Interface
- SETS, 16: number of frames; power of two, 2..256; IDX_W = log2(SETS)
- CLK  in  1  rising-edge clock
- nRST  in  1  reset, synchronous, active-high (1 = reset)
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- ihit  out  1  fetch data valid this cycle
- imemload  out  32  fetched instruction; 0 when ihit = 0
- flush  in  1  invalidate all frames
- iREN  out  1  memory read request
- iaddr  out  32  memory word address, bits [1:0] = 0
- iwait  in  1  memory busy; iload is valid in the cycle iwait = 0 while iREN = 1
- iload  in  32  memory read data
- hit_count  out  32  performance counter (see Configuration)
- miss_count  out  32  performance counter (see Configuration)

## Operation
- Address split: index = imemaddr[IDX_W+1:2]; tag = imemaddr[31:IDX_W+2].
- Frame contents: valid bit, tag, and 32-bit data.
- States: IDLE and FETCH.
- IDLE:
  - Hit is imemREN & valid[index] & (tag match).
  - On a hit: ihit = 1 and imemload = data[index], both combinational.
  - On imemREN & !hit & !flush: latch the word address into miss_addr and go to FETCH.
  - With imemREN = 0: no request, and ihit = 0.
- FETCH:
  - iREN = 1 and iaddr = miss_addr throughout; ihit = 0.
  - When iwait = 0, write iload and the tag into frame miss_addr index, set valid, and return to IDLE.
- The refill always targets the latched miss_addr. If imemaddr changes during FETCH, the fill still completes and the new address is looked up in IDLE afterwards.
- flush:
  - All valid bits clear at the clock edge; tags and data are left unchanged.
  - In the same cycle, flush forces ihit = 0.
  - Flush during FETCH: the fill word is discarded (valid stays 0) if the fill completes in the same cycle or later. The FSM still waits for iwait = 0, then returns to IDLE.
  - Flush and a fill completing in the same cycle: flush wins, and the frame is left invalid.
- Conflict: a fill overwrites the frame at the same index unconditionally.
- Reset values:
  - State = IDLE; all valid = 0; miss_addr = 0; discard flag = 0.
  - Outputs: iREN = 0, iaddr = 0, ihit = 0, imemload = 0, hit_count = 0, miss_count = 0.
- Reset mid-FETCH: immediate return to IDLE with iREN = 0. Any late iload is ignored.

## Timing
- Hit latency: 0 cycles; ihit is asserted in the same cycle as the request.
- Miss:
  - Cycle 0: lookup misses.
  - Cycle 1 onward: iREN = 1.
  - Fill lands at the first edge with iwait = 0.
  - ihit rises the cycle after the fill, provided imemaddr is unchanged.
  - Total for a miss against memory with N wait cycles: N + 2 cycles until ihit.
- Only one memory request is outstanding at a time. iREN deasserts for at least one cycle between refills.

## Configuration
- ICACHE_PERF_EN defined:
  - hit_count increments in every IDLE cycle with ihit = 1.
  - miss_count increments on every IDLE to FETCH transition.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on nRST (not on flush).
- ICACHE_PERF_EN undefined: the ports remain, tied to 0, and no counter flops are built.

## Structure
- cpu_types_pkg holds word_t plus these icache definitions:
  - icachef_t: packed {tag, idx, bytoff} address view
  - icache_frame_t: {valid, tag, data}
  - icache_state_t enum {ICACHE_IDLE, ICACHE_FETCH}
  - constants ICACHE_IDX_W and ICACHE_TAG_W
- No sub-module: the frame array, FSM and counters live in icache_direct.

## Test plan
- Reset checks:
  - Assert nRST for 2 cycles with imemREN = 1 and imemaddr = 0x0.
  - Require ihit = 0, iREN = 0 and counters = 0.
- Cold miss:
  - imemaddr = 0x00000004 with iwait held 1 for 2 cycles; iload = 0x8C010000.
  - Require iREN = 1 with iaddr = 0x4 for 3 cycles.
  - Require ihit = 1 and imemload = 0x8C010000 four cycles after the request.
- Conflict eviction:
  - Fill 0x00 (iload = 0xAAAA0000), then 0x40 (iload = 0xBBBB0000); both share index 0 with SETS = 16.
  - Re-request 0x00: it must miss again, and miss_count = 3.
- Flush:
  - Warm 0x08, assert flush for 1 cycle, re-request 0x08.
  - Require ihit = 0 and a new refill.
  - Repeat with flush asserted in the cycle iwait = 0: the frame must stay invalid.
- Address change during FETCH:
  - Miss on 0x10, change imemaddr to 0x14 while waiting.
  - Require the fill to go to index 4 with the 0x10 tag, followed by a new miss on 0x14.
- Perf counters (ICACHE_PERF_EN):
  - 10 consecutive hit cycles on 0x04 after a fill.
  - Require hit_count = 10 and miss_count = 1.
  - With the macro undefined, both counters must read 0.
